// File: rtl/urv_defs.sv
// Shared definitions for the uRV writeback stage: load funct3 codes,
// result-source encodings and writeback FSM states.
package urv_defs;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_L  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   localparam logic [1:0] RD_SOURCE_ALU      = 2'b00;
   localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'b01;
   localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'b10;
   localparam logic [1:0] RD_SOURCE_DIVIDE   = 2'b11;

   typedef enum logic [1:0] {
      WB_IDLE     = 2'b00,
      WB_WAIT_MEM = 2'b01,
      WB_HELD     = 2'b10
   } wb_state_t;

endpackage

// File: rtl/urv_load_align.sv
// Load data alignment: picks the byte/halfword lane selected by the low
// address bits and sign- or zero-extends it according to the load funct3.
module urv_load_align
   import urv_defs::*;
(
   input  logic [2:0]  fun,
   input  logic [1:0]  addr,
   input  logic [31:0] data,
   output logic [31:0] value
);

   logic [3:0][7:0]  bytes;
   logic [1:0][15:0] halves;
   logic [7:0]       b;
   logic [15:0]      h;

   assign bytes  = data;
   assign halves = data;
   assign b      = bytes[addr];
   assign h      = halves[addr[1]];

   always_comb begin
      value = 32'h0;
      case (fun)
         LDST_B:  value = {{24{b[7]}}, b};
         LDST_BU: value = {24'h0, b};
         LDST_H:  value = {{16{h[15]}}, h};
         LDST_HU: value = {16'h0, h};
         LDST_L:  value = data;
         default: value = 32'h0;
      endcase
   end

endmodule

// File: rtl/urv_writeback.sv
// uRV writeback stage: result select, load alignment, one RF write per
// committed instruction, memory-completion stall. URV_WB_BYPASS_EN adds the bypass register.
module urv_writeback
   import urv_defs::*;
#(
   parameter int g_with_hw_mul = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        w_stall_i,
   output logic        w_stall_req_o,

   input  logic [2:0]  w_fun_i,
   input  logic        w_load_i,
   input  logic        w_store_i,
   input  logic        w_valid_i,
   input  logic [4:0]  w_rd_i,
   input  logic [31:0] w_rd_value_i,
   input  logic        w_rd_write_i,
   input  logic [31:0] w_dm_addr_i,
   input  logic [1:0]  w_rd_source_i,
   input  logic [31:0] w_rd_shifter_i,
   input  logic [31:0] w_rd_multiply_i,

   input  logic [31:0] dm_data_l_i,
   input  logic        dm_load_done_i,
   input  logic        dm_store_done_i,

   output logic [4:0]  rf_rd_o,
   output logic [31:0] rf_rd_value_o,
   output logic        rf_rd_write_o,

   output logic [4:0]  x_bypass_rd_o,
   output logic [31:0] x_bypass_value_o,
   output logic        x_bypass_valid_o
);

   wb_state_t   state, state_nxt;
   logic [31:0] hold_q;
   logic        mem_acc, done_match;
   logic        stall_req, latch_hold, ld_data_ok;
   logic [31:0] ld_src, ld_value, alu_value;
   logic        wr_base;
   logic        unused_addr;

   assign unused_addr = ^w_dm_addr_i[31:2];

   assign mem_acc    = (w_load_i | w_store_i) & w_valid_i;
   assign done_match = (w_load_i & dm_load_done_i) | (w_store_i & dm_store_done_i);

   // A completion seen while the pipeline is frozen is parked in HELD so the
   // data survives until the instruction is allowed to retire.
   always_comb begin
      state_nxt  = state;
      stall_req  = 1'b0;
      latch_hold = 1'b0;
      ld_data_ok = 1'b0;
      case (state)
         WB_IDLE:
            if (mem_acc) begin
               if (!done_match) begin
                  state_nxt = WB_WAIT_MEM;
                  stall_req = 1'b1;
               end else begin
                  ld_data_ok = 1'b1;
                  if (w_stall_i) begin
                     state_nxt  = WB_HELD;
                     latch_hold = 1'b1;
                  end
               end
            end
         WB_WAIT_MEM:
            if (!done_match) begin
               stall_req = 1'b1;
            end else begin
               ld_data_ok = 1'b1;
               if (w_stall_i) begin
                  state_nxt  = WB_HELD;
                  latch_hold = 1'b1;
               end else begin
                  state_nxt = WB_IDLE;
               end
            end
         WB_HELD: begin
            ld_data_ok = 1'b1;
            if (!w_stall_i)
               state_nxt = WB_IDLE;
         end
         default: state_nxt = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= WB_IDLE;
         hold_q <= 32'h0;
      end else begin
         state <= state_nxt;
         if (latch_hold)
            hold_q <= dm_data_l_i;
      end
   end

   assign ld_src = (state == WB_HELD) ? hold_q : dm_data_l_i;

   urv_load_align u_align (
      .fun   (w_fun_i),
      .addr  (w_dm_addr_i[1:0]),
      .data  (ld_src),
      .value (ld_value)
   );

   always_comb begin
      alu_value = w_rd_value_i;
      case (w_rd_source_i)
         RD_SOURCE_SHIFTER:  alu_value = w_rd_shifter_i;
         RD_SOURCE_MULTIPLY: alu_value = (g_with_hw_mul != 0) ? w_rd_multiply_i : w_rd_value_i;
         default:            alu_value = w_rd_value_i;
      endcase
   end

   assign wr_base       = w_rd_write_i & w_valid_i & ~w_stall_i & (w_rd_i != 5'd0) & ~rst_i;
   assign rf_rd_o       = w_rd_i;
   assign rf_rd_value_o = w_load_i ? ld_value : alu_value;
   assign rf_rd_write_o = wr_base & (w_load_i ? ld_data_ok : ~w_store_i);
   assign w_stall_req_o = stall_req & ~rst_i;

`ifdef URV_WB_BYPASS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_bypass_rd_o    <= 5'd0;
         x_bypass_value_o <= 32'h0;
         x_bypass_valid_o <= 1'b0;
      end else if (rf_rd_write_o) begin
         x_bypass_rd_o    <= rf_rd_o;
         x_bypass_value_o <= rf_rd_value_o;
         x_bypass_valid_o <= 1'b1;
      end
   end
`else
   assign x_bypass_rd_o    = 5'd0;
   assign x_bypass_value_o = 32'h0;
   assign x_bypass_valid_o = 1'b0;
`endif

endmodule

// File: doc/urv_writeback.md
# urv_writeback

Writeback (W) stage of the uRV pipeline, directly downstream of the execute stage. It consumes the X/W pipeline registers and the data-memory completion signals. It selects and aligns the result (ALU/CSR, shifter, multiplier or load data) and issues exactly one register-file write per committed instruction. It also stalls the pipeline until outstanding loads and stores complete.

## Interface
Parameters:
- g_with_hw_mul, 1, 1 = multiplier result source legal; 0 = source 2'b10 treated as ALU.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- w_stall_i  in  1  global stall from pipeline control
- w_stall_req_o  out  1  W requests pipeline stall
- w_fun_i  in  3  load funct3 (LDST_B/H/L/BU/HU)
- w_load_i  in  1  instruction is a load
- w_store_i  in  1  instruction is a store
- w_valid_i  in  1  instruction valid
- w_rd_i  in  5  destination register
- w_rd_value_i  in  32  ALU/CSR/div/mulh result
- w_rd_write_i  in  1  instruction writes rd
- w_dm_addr_i  in  32  load/store address (bits [1:0] used)
- w_rd_source_i  in  2  result source
- w_rd_shifter_i  in  32  shifter result
- w_rd_multiply_i  in  32  multiplier low result
- dm_data_l_i  in  32  load data, valid with dm_load_done_i
- dm_load_done_i  in  1  load data strobe (1 cycle)
- dm_store_done_i  in  1  store completion strobe (1 cycle)
- rf_rd_o  out  5  RF write address
- rf_rd_value_o  out  32  RF write data
- rf_rd_write_o  out  1  RF write enable
- x_bypass_rd_o  out  5  last written register
- x_bypass_value_o  out  32  last written value
- x_bypass_valid_o  out  1  bypass entry valid

## Operation
- Result mux: w_rd_source_i 00 = w_rd_value_i, 01 = shifter, 10 = multiply (if g_with_hw_mul), 11 = w_rd_value_i. Load overrides to aligned load data.
- Load align by w_dm_addr_i[1:0]:
  - B/BU: byte lane addr[1:0], sign-/zero-extend.
  - H/HU: halfword lane addr[1], sign-/zero-extend.
  - L: full word.
  - Other funct3: zero.
- FSM states:
  - IDLE
  - WAIT_MEM: access outstanding, stall requested.
  - HELD: load data captured while externally stalled.
- IDLE transitions:
  - Stay in IDLE if (w_load_i|w_store_i)&w_valid_i and matching done strobe present this cycle. Commit immediately.
  - Go to WAIT_MEM if same condition and done strobe absent. w_stall_req_o=1 combinationally in that same cycle.
- WAIT_MEM transitions:
  - w_stall_req_o=1 until matching done strobe.
  - On strobe with w_stall_i=0: commit, go to IDLE.
  - On strobe with w_stall_i=1: latch dm_data_l_i into hold register, go to HELD.
- HELD: w_stall_req_o=0. When w_stall_i drops, commit from hold register, go to IDLE.
- Commit for a non-memory instruction: rf_rd_write_o = w_rd_write_i & w_valid_i & !w_stall_i & (rf_rd_o != 0).
- Commit for a load: rf_rd_write_o = w_rd_write_i & w_valid_i & !w_stall_i & (rf_rd_o != 0), gated additionally by data availability.
- Stores never write the RF.
- A done strobe outside WAIT_MEM, or in IDLE without a matching access, is ignored.

## Timing
- RF write is combinational from the W registers/FSM. The RF samples it at the next rising edge, so there is zero added latency for non-memory instructions.
- Load latency: a strobe in the first W cycle gives 0 stall cycles. Otherwise the stall lasts N cycles, where N is the number of cycles from the first W cycle until the strobe.
- Bypass entry registered: updates at the edge following each RF write (rd, value, valid=1). It holds otherwise.
- Reset values:
  - w_stall_req_o=0, rf_rd_write_o=0 and all bypass outputs 0.
  - FSM is in IDLE and the hold register is 0.
- Reset mid-WAIT_MEM or mid-HELD: return to IDLE, discard data, no RF write.

## Configuration
- URV_WB_BYPASS_EN defined: bypass register implemented as above.
- URV_WB_BYPASS_EN undefined: x_bypass_* tied to 0, no bypass flops, all other behaviour identical.

## Structure
- Shared package/defs (urv_defs): LDST_* funct3 codes, RD_SOURCE W encodings (2-bit), FSM state encodings.
- One natural sub-module: urv_load_align (combinational funct3/addr/data → 32-bit aligned value).

## Test plan
- Load word at 0x100 with done in the first W cycle and data 0xDEADBEEF, rd=5 → rf write x5=0xDEADBEEF in the same cycle, w_stall_req_o never 1.
- LB, addr[1:0]=2'b11, data 0x80123456 → 0xFFFFFF80. LBU → 0x00000080. LHU, addr[1]=1 → 0x00008012.
- Load with done 3 cycles late → w_stall_req_o high exactly 3 cycles, single rf write on the strobe cycle.
- Strobe arrives while w_stall_i=1 → state HELD, no write. w_stall_i drops 2 cycles later → one write with the latched value.
- rd=0 ALU op with value 0x1234 → rf_rd_write_o=0, bypass unchanged. Shifter source 0x55 to rd=7 → x7=0x55, bypass (7,0x55,1) next cycle.
- Reset asserted during WAIT_MEM, strobe after reset → no RF write, all outputs at reset values.
